// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: FSM state encoding for the
// countdown timer and the load-clamp helper.
package counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } countdown_state_e;

  // Saturate a requested count into the legal range 0..limit-1.
  function automatic int clamp_load(input int value, input int limit);
    return (value >= limit) ? (limit - 1) : value;
  endfunction

endpackage

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with ready/valid load handshake,
// decrement strobes, abort, and a registered one-cycle expiry pulse.
// Optional build macro COUNTDOWN_TIMER_AUTO_RELOAD_EN: on expiry the count
// reloads from the last loaded value and the countdown keeps running until
// aborted.
module countdown_timer
  import counter_pkg::*;
#(
  parameter int    Limit = 16,
  localparam byte  Width = byte'($clog2(Limit))
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [Width-1:0] load_value_i,
  input  logic             dec_i,
  input  logic             abort_i,
  output logic [Width-1:0] value_o,
  output logic             busy_o,
  output logic             will_underflow_o,
  output logic             expire_o
);

  countdown_state_e state_q, state_d;
  logic [Width-1:0] value_q, value_d;
  logic             expire_q, expire_d;
  logic [Width-1:0] load_clamped;
  logic             at_one;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [Width-1:0] reload_q, reload_d;
`endif

  assign load_clamped = Width'(clamp_load(32'(load_value_i), Limit));
  assign at_one       = (value_q == Width'(1));

  // Next-state and datapath: a load is only possible in IDLE; in RUN abort wins over dec.
  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    expire_d = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (load_valid_i) begin
          value_d = load_clamped;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
          reload_d = load_clamped;
`endif
          // A zero start value expires immediately without entering RUN.
          if (load_clamped != '0) state_d  = RUN;
          else                    expire_d = 1'b1;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
          value_d = '0;
        end else if (dec_i) begin
          if (at_one) begin
            expire_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            value_d  = reload_q;
`else
            state_d  = IDLE;
            value_d  = '0;
`endif
          end else begin
            value_d = value_q - Width'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        value_d = '0;
      end
    endcase
  end

  // State, count and expiry registers; everything clears on async reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      value_q  <= '0;
      expire_q <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      expire_q <= expire_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign busy_o           = (state_q == RUN);
  assign load_ready_o     = (state_q == IDLE);
  assign will_underflow_o = (state_q == RUN) && at_one;
  assign value_o          = value_q;
  assign expire_o         = expire_q;

endmodule
